// File: rtl/color_analysis_hls_dl_pkg.sv
// Shared types for the dataflow deadlock report unit: FSM state encoding and
// the origin-index width helper.
package color_analysis_hls_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } dl_state_e;

  // A single-process region still needs a one-bit index.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/color_analysis_hls_dl_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest requesting
// process and whether any request is present.
module color_analysis_hls_dl_prio_enc
  import color_analysis_hls_dl_pkg::*;
#(
  parameter int N = 4,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = i[W-1:0];
    end
  end

endmodule

// File: rtl/color_analysis_hls_deadlock_report_unit.sv
// Central deadlock report unit for one dataflow region: elects an origin,
// follows the token walk, clears it on return and reports the cycle.
// Optional counter timeout of the walk: define COLOR_ANALYSIS_DL_TIMEOUT_EN.
module color_analysis_hls_deadlock_report_unit
  import color_analysis_hls_dl_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = id_width(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_detect_bcast,
  output logic                dl_valid,
  output logic [ID_W-1:0]     dl_origin_id,
  output logic [PROC_NUM-1:0] dl_cycle_mask,
  output logic                dl_found
);

  localparam int STEP_W = $clog2(TIMEOUT_CYCLES + 1);

  dl_state_e           state_q, state_d;
  logic [ID_W-1:0]     origin_id_q, origin_id_d;
  logic [PROC_NUM-1:0] origin_q, origin_d;
  logic [PROC_NUM-1:0] mask_q, mask_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                bcast_q, bcast_d;
  logic                valid_q, valid_d;
  logic                found_q, found_d;
  logic [PROC_NUM-1:0] cmask_q, cmask_d;

  logic [ID_W-1:0]     enc_idx;
  logic                enc_any;
  logic [PROC_NUM-1:0] oid_oh;
  logic                tok_ret;
  logic                tok_tmo;

  color_analysis_hls_dl_prio_enc #(
    .N (PROC_NUM)
  ) u_prio_enc (
    .req_i (dl_detect_vec),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_comb begin
    state_d     = state_q;
    origin_id_d = origin_id_q;
    origin_d    = '0;
    mask_d      = mask_q;
    step_d      = step_q;
    bcast_d     = bcast_q;
    valid_d     = 1'b0;
    found_d     = found_q;
    cmask_d     = cmask_q;
    oid_oh      = '0;
    oid_oh[origin_id_q] = 1'b1;
    tok_ret     = 1'b0;
    tok_tmo     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          origin_id_d       = enc_idx;
          origin_d[enc_idx] = 1'b1;
          bcast_d           = 1'b1;
          mask_d            = '0;
          step_d            = '0;
          state_d           = ST_WALK;
        end
      end
      ST_WALK: begin
        mask_d = mask_q | token_vec;
        if (step_q != '1) step_d = step_q + STEP_W'(1);
        // step 0 is the cycle the origin launches the token; it cannot have returned yet.
        tok_ret = dl_detect_vec[origin_id_q] & token_vec[origin_id_q] & (step_q != '0);
        if (tok_ret) begin
          state_d = ST_REPORT;
          valid_d = 1'b1;
          found_d = 1'b1;
          cmask_d = mask_q | token_vec | oid_oh;
        end
`ifdef COLOR_ANALYSIS_DL_TIMEOUT_EN
        else if (step_q == STEP_W'(TIMEOUT_CYCLES)) begin
          tok_tmo = 1'b1;
          state_d = ST_IDLE;
          bcast_d = 1'b0;
          mask_d  = '0;
        end
`endif
      end
      ST_REPORT: state_d = ST_HOLD;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      origin_id_q <= '0;
      origin_q    <= '0;
      mask_q      <= '0;
      step_q      <= '0;
      bcast_q     <= 1'b0;
      valid_q     <= 1'b0;
      found_q     <= 1'b0;
      cmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      origin_id_q <= origin_id_d;
      origin_q    <= origin_d;
      mask_q      <= mask_d;
      step_q      <= step_d;
      bcast_q     <= bcast_d;
      valid_q     <= valid_d;
      found_q     <= found_d;
      cmask_q     <= cmask_d;
    end
  end

  assign origin          = origin_q;
  assign token_clear     = tok_ret | tok_tmo;
  assign dl_detect_bcast = bcast_q;
  assign dl_valid        = valid_q;
  assign dl_origin_id    = origin_id_q;
  assign dl_cycle_mask   = cmask_q;
  assign dl_found        = found_q;

endmodule

// File: tb/tb_color_analysis_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit (PROC_NUM=4, TIMEOUT_CYCLES=16).
module tb_color_analysis_hls_deadlock_report_unit;

`ifdef COLOR_ANALYSIS_DL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dl_detect_vec = '0;
  logic [3:0] token_vec = '0;
  logic [3:0] origin;
  logic       token_clear;
  logic       dl_detect_bcast;
  logic       dl_valid;
  logic [1:0] dl_origin_id;
  logic [3:0] dl_cycle_mask;
  logic       dl_found;

  int n_chk  = 0;
  int n_fail = 0;

  color_analysis_hls_deadlock_report_unit #(
    .PROC_NUM       (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .dl_detect_vec   (dl_detect_vec),
    .token_vec       (token_vec),
    .origin          (origin),
    .token_clear     (token_clear),
    .dl_detect_bcast (dl_detect_bcast),
    .dl_valid        (dl_valid),
    .dl_origin_id    (dl_origin_id),
    .dl_cycle_mask   (dl_cycle_mask),
    .dl_found        (dl_found)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven, checks follow #1 later.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".origin"}, 32'(origin), 32'h0);
    check({tag, ".tclr"},   32'(token_clear), 32'h0);
    check({tag, ".bcast"},  32'(dl_detect_bcast), 32'h0);
    check({tag, ".valid"},  32'(dl_valid), 32'h0);
    check({tag, ".oid"},    32'(dl_origin_id), 32'h0);
    check({tag, ".mask"},   32'(dl_cycle_mask), 32'h0);
    check({tag, ".found"},  32'(dl_found), 32'h0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    dl_detect_vec = '0;
    token_vec     = '0;
    #1 check_all_zero("rst_async");
    tick();
    #1 reset = 1'b1;
  endtask

  initial begin
    // Power-on reset
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check_all_zero("por");
    reset = 1'b1;

    // T2: origin election, token walk and report
    tick(); dl_detect_vec = 4'b0100; token_vec = 4'b0000;
    #1 check("t2.idle_origin", 32'(origin), 32'h0);
    check("t2.idle_tclr", 32'(token_clear), 32'h0);
    tick(); dl_detect_vec = 4'b0000;
    #1 check("t2.origin", 32'(origin), 32'h4);
    check("t2.bcast", 32'(dl_detect_bcast), 32'h1);
    check("t2.oid_walk", 32'(dl_origin_id), 32'h2);
    check("t2.tclr_w0", 32'(token_clear), 32'h0);
    tick(); token_vec = 4'b0001;
    #1 check("t2.origin_w1", 32'(origin), 32'h0);
    check("t2.tclr_w1", 32'(token_clear), 32'h0);
    tick(); token_vec = 4'b1000;
    #1 check("t2.tclr_w2", 32'(token_clear), 32'h0);
    tick(); token_vec = 4'b0100; dl_detect_vec = 4'b0100;
    #1 check("t2.tclr_ret", 32'(token_clear), 32'h1);
    check("t2.valid_ret", 32'(dl_valid), 32'h0);
    tick(); token_vec = 4'b0000; dl_detect_vec = 4'b0000;
    #1 check("t2.valid", 32'(dl_valid), 32'h1);
    check("t2.mask", 32'(dl_cycle_mask), 32'hd);
    check("t2.oid", 32'(dl_origin_id), 32'h2);
    check("t2.found", 32'(dl_found), 32'h1);
    check("t2.tclr_rep", 32'(token_clear), 32'h0);
    tick();
    #1 check("t2.valid_pulse", 32'(dl_valid), 32'h0);
    check("t2.found_hold", 32'(dl_found), 32'h1);
    check("t2.bcast_hold", 32'(dl_detect_bcast), 32'h1);

    // T6: HOLD ignores all inputs
    for (int i = 0; i < 10; i++) begin
      tick(); dl_detect_vec = 4'b1111; token_vec = 4'b1111;
      #1 check("t6.origin", 32'(origin), 32'h0);
      check("t6.valid", 32'(dl_valid), 32'h0);
      check("t6.found", 32'(dl_found), 32'h1);
      check("t6.tclr", 32'(token_clear), 32'h0);
      check("t6.mask", 32'(dl_cycle_mask), 32'hd);
    end

    // T1: asynchronous reset mid-stream, then IDLE with no origin pulse
    do_reset();
    tick();
    #1 check("t1.origin", 32'(origin), 32'h0);
    check("t1.bcast", 32'(dl_detect_bcast), 32'h0);
    check("t1.found", 32'(dl_found), 32'h0);
    tick();
    #1 check("t1.origin2", 32'(origin), 32'h0);

    // T3: lowest requester wins
    dl_detect_vec = 4'b1010;
    tick(); dl_detect_vec = 4'b0000;
    #1 check("t3.origin", 32'(origin), 32'h2);
    check("t3.oid", 32'(dl_origin_id), 32'h1);

    // T5: non-origin detect ignored during WALK
    do_reset();
    tick(); dl_detect_vec = 4'b0001;
    tick(); dl_detect_vec = 4'b0000;
    #1 check("t5.origin", 32'(origin), 32'h1);
    tick(); dl_detect_vec = 4'b1000; token_vec = 4'b1000;
    #1 check("t5.tclr_nonorig", 32'(token_clear), 32'h0);
    tick(); dl_detect_vec = 4'b1001; token_vec = 4'b1000;
    #1 check("t5.tclr_notok", 32'(token_clear), 32'h0);
    tick(); dl_detect_vec = 4'b0000; token_vec = 4'b0000;
    #1 check("t5.origin_idle", 32'(origin), 32'h0);
    check("t5.oid", 32'(dl_origin_id), 32'h0);
    check("t5.bcast", 32'(dl_detect_bcast), 32'h1);

    // T4: walk continues to step 16 with no return (now at step 3)
    for (int s = 4; s < 16; s++) begin
      tick();
      #1 check("t4.tclr_walk", 32'(token_clear), 32'h0);
      check("t4.valid_walk", 32'(dl_valid), 32'h0);
    end
    tick();
    #1 check("t4.tclr_tmo", 32'(token_clear), TMO_EN ? 32'h1 : 32'h0);
    check("t4.valid_tmo", 32'(dl_valid), 32'h0);
    tick(); dl_detect_vec = 4'b0001;
    #1 check("t4.bcast", 32'(dl_detect_bcast), TMO_EN ? 32'h0 : 32'h1);
    check("t4.found", 32'(dl_found), 32'h0);
    check("t4.valid", 32'(dl_valid), 32'h0);
    check("t4.tclr_after", 32'(token_clear), 32'h0);
    tick(); dl_detect_vec = 4'b0000;
    #1 check("t4.reelect", 32'(origin), TMO_EN ? 32'h1 : 32'h0);
    check("t4.bcast2", 32'(dl_detect_bcast), 32'h1);
    check("t4.found2", 32'(dl_found), 32'h0);
    check("t4.valid2", 32'(dl_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
